// File: rtl/order_payload_pkg.sv
// Shared constants for the order-message serializer: frame geometry, field byte
// offsets inside the 96-byte big-endian frame, and the FSM state type.
package order_payload_pkg;

  localparam int DATA_W      = 256;
  localparam int NUM_BEATS   = 3;
  localparam int FRAME_BYTES = 96;
  localparam int FRAME_W     = FRAME_BYTES * 8;
  localparam int BODY_BYTES  = 67;
  localparam int BODY_W      = BODY_BYTES * 8;

  localparam int PRICE_OFS     = 0;
  localparam int QTY_OFS       = 4;
  localparam int SEQ_OFS       = 6;
  localparam int EPOCH_OFS     = 10;
  localparam int MS_OFS        = 14;
  localparam int SESSION_OFS   = 16;
  localparam int CM_OFS        = 18;
  localparam int EXEC_OFS      = 20;
  localparam int ACNO_OFS      = 21;
  localparam int FLAG_OFS      = 25;
  localparam int SIDE_OFS      = 26;
  localparam int ORDTYPE_OFS   = 27;
  localparam int TIF_OFS       = 28;
  localparam int ORDER_NO_OFS  = 29;
  localparam int ORD_ID_OFS    = 34;
  localparam int USER_DEF_OFS  = 38;
  localparam int SYM_TYPE_OFS  = 46;
  localparam int SYM_OFS       = 47;
  localparam int CHECKSUM_OFS  = 67;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  // Bit index of the MSB of byte `ofs` in the body vector (byte 0 at the top).
  function automatic int body_msb(input int ofs);
    return BODY_W - 1 - 8 * ofs;
  endfunction

endpackage

// File: rtl/order_payload_if.sv
// AXI-Stream style transmit channel of the serializer, plus the beat index.
interface order_payload_if;
  import order_payload_pkg::*;

  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] data;
  logic [2:0]        cnt;

  modport master (output tvalid, tlast, data, cnt, input tready);
  modport slave  (input tvalid, tlast, data, cnt, output tready);
endinterface

// File: rtl/order_payload_csum.sv
// Mod-256 sum of the 67 frame body bytes (byte 0 in the top bits of body).
module order_payload_csum
  import order_payload_pkg::*;
(
  input  logic [BODY_W-1:0] body,
  output logic [7:0]        csum
);

  // NOTE: blocking assignments are correct here; the loop is an accumulation
  // chain evaluated in order within one combinational pass.
  always_comb begin
    csum = '0;
    for (int i = 0; i < BODY_BYTES; i++) begin
      csum = csum + body[i*8 +: 8];
    end
  end

endmodule

// File: rtl/order_payload.sv
// Order-message serializer: captures an order record on enable and streams it
// as three 256-bit big-endian beats with a trailing checksum byte.
module order_payload
  import order_payload_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [31:0]  price,
  input  logic [15:0]  qty,
  input  logic [31:0]  MsgSeqNum,
  input  logic [31:0]  epoch_s,
  input  logic [15:0]  ms,
  input  logic [15:0]  session_id,
  input  logic [15:0]  cm_id,
  input  logic [7:0]   ExecType,
  input  logic [31:0]  investor_acno,
  input  logic [7:0]   investor_flag,
  input  logic [7:0]   side,
  input  logic [7:0]   OrdType,
  input  logic [7:0]   TimeInForce,
  input  logic [7:0]   order_no0,
  input  logic [7:0]   order_no1,
  input  logic [7:0]   order_no2,
  input  logic [7:0]   order_no3,
  input  logic [7:0]   order_no4,
  input  logic [31:0]  ord_id,
  input  logic [7:0]   user_define0,
  input  logic [7:0]   user_define1,
  input  logic [7:0]   user_define2,
  input  logic [7:0]   user_define3,
  input  logic [7:0]   user_define4,
  input  logic [7:0]   user_define5,
  input  logic [7:0]   user_define6,
  input  logic [7:0]   user_define7,
  input  logic [7:0]   symbol_type,
  input  logic [159:0] sym,
  order_payload_if.master axis
);

  logic [BODY_W-1:0]  body;
  logic [7:0]         csum;
  logic [FRAME_W-1:0] frame_d;
  logic [FRAME_W-1:0] frame_q;
  logic [DATA_W-1:0]  data_q;
  logic [2:0]         cnt_q;
  logic               tvalid_q;
  logic               tlast_q;
  state_t             state;

  always_comb begin
    body = '0;
    body[body_msb(PRICE_OFS)      -: 32]  = price;
    body[body_msb(QTY_OFS)        -: 16]  = qty;
    body[body_msb(SEQ_OFS)        -: 32]  = MsgSeqNum;
    body[body_msb(EPOCH_OFS)      -: 32]  = epoch_s;
    body[body_msb(MS_OFS)         -: 16]  = ms;
    body[body_msb(SESSION_OFS)    -: 16]  = session_id;
    body[body_msb(CM_OFS)         -: 16]  = cm_id;
    body[body_msb(EXEC_OFS)       -: 8]   = ExecType;
    body[body_msb(ACNO_OFS)       -: 32]  = investor_acno;
    body[body_msb(FLAG_OFS)       -: 8]   = investor_flag;
    body[body_msb(SIDE_OFS)       -: 8]   = side;
    body[body_msb(ORDTYPE_OFS)    -: 8]   = OrdType;
    body[body_msb(TIF_OFS)        -: 8]   = TimeInForce;
    body[body_msb(ORDER_NO_OFS)   -: 8]   = order_no0;
    body[body_msb(ORDER_NO_OFS+1) -: 8]   = order_no1;
    body[body_msb(ORDER_NO_OFS+2) -: 8]   = order_no2;
    body[body_msb(ORDER_NO_OFS+3) -: 8]   = order_no3;
    body[body_msb(ORDER_NO_OFS+4) -: 8]   = order_no4;
    body[body_msb(ORD_ID_OFS)     -: 32]  = ord_id;
    body[body_msb(USER_DEF_OFS)   -: 8]   = user_define0;
    body[body_msb(USER_DEF_OFS+1) -: 8]   = user_define1;
    body[body_msb(USER_DEF_OFS+2) -: 8]   = user_define2;
    body[body_msb(USER_DEF_OFS+3) -: 8]   = user_define3;
    body[body_msb(USER_DEF_OFS+4) -: 8]   = user_define4;
    body[body_msb(USER_DEF_OFS+5) -: 8]   = user_define5;
    body[body_msb(USER_DEF_OFS+6) -: 8]   = user_define6;
    body[body_msb(USER_DEF_OFS+7) -: 8]   = user_define7;
    body[body_msb(SYM_TYPE_OFS)   -: 8]   = symbol_type;
    body[body_msb(SYM_OFS)        -: 160] = sym;
  end

  order_payload_csum u_csum (
    .body (body),
    .csum (csum)
  );

  // Checksum sits right after the body; the remaining tail bytes are padding.
  assign frame_d = {body, csum, {(FRAME_W - BODY_W - 8){1'b0}}};

  // NOTE: every register here, including the wide frame capture, is reset
  // because idle outputs must read as zero; all state uses non-blocking <=.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= ST_IDLE;
      frame_q  <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            frame_q  <= frame_d;
            data_q   <= frame_d[FRAME_W-1 -: DATA_W];
            cnt_q    <= 3'd1;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // tvalid is always high in SEND, so tready alone completes a beat.
          if (axis.tready) begin
            if (cnt_q == 3'(NUM_BEATS)) begin
              data_q   <= '0;
              cnt_q    <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              data_q  <= (cnt_q == 3'd1) ? frame_q[FRAME_W-1-DATA_W -: DATA_W]
                                         : frame_q[DATA_W-1:0];
              cnt_q   <= cnt_q + 3'd1;
              tlast_q <= (cnt_q + 3'd1 == 3'(NUM_BEATS));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign axis.tvalid = tvalid_q;
  assign axis.tlast  = tlast_q;
  assign axis.data   = data_q;
  assign axis.cnt    = cnt_q;

endmodule

// File: tb/tb_order_payload.sv
// Directed bench for order_payload: a byte-array frame model feeds a beat
// scoreboard that is drained as the DUT hands beats off on the stream.
module tb_order_payload;
  import order_payload_pkg::*;

  typedef struct {
    logic [255:0] data;
    logic         last;
    logic [2:0]   cnt;
  } beat_t;

  logic         clk = 1'b0;
  logic         resetn, enable;
  logic [31:0]  price, MsgSeqNum, epoch_s, investor_acno, ord_id;
  logic [15:0]  qty, ms, session_id, cm_id;
  logic [7:0]   ExecType, investor_flag, side, OrdType, TimeInForce, symbol_type;
  logic [7:0]   order_no [5];
  logic [7:0]   user_def [8];
  logic [159:0] sym;

  logic [7:0]   exp_frame [FRAME_BYTES];
  logic [255:0] obs_beat [1:3];
  beat_t        sb [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  order_payload_if axis ();

  order_payload dut (
    .clk (clk), .resetn (resetn), .enable (enable),
    .price (price), .qty (qty), .MsgSeqNum (MsgSeqNum), .epoch_s (epoch_s),
    .ms (ms), .session_id (session_id), .cm_id (cm_id), .ExecType (ExecType),
    .investor_acno (investor_acno), .investor_flag (investor_flag), .side (side),
    .OrdType (OrdType), .TimeInForce (TimeInForce),
    .order_no0 (order_no[0]), .order_no1 (order_no[1]), .order_no2 (order_no[2]),
    .order_no3 (order_no[3]), .order_no4 (order_no[4]), .ord_id (ord_id),
    .user_define0 (user_def[0]), .user_define1 (user_def[1]),
    .user_define2 (user_def[2]), .user_define3 (user_def[3]),
    .user_define4 (user_def[4]), .user_define5 (user_def[5]),
    .user_define6 (user_def[6]), .user_define7 (user_def[7]),
    .symbol_type (symbol_type), .sym (sym),
    .axis (axis.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cnt"},    256'(axis.cnt),    256'(0));
    check({tag, " tvalid"}, 256'(axis.tvalid), 256'(0));
    check({tag, " tlast"},  256'(axis.tlast),  256'(0));
    check({tag, " data"},   axis.data,         256'(0));
  endtask

  task automatic put_be(input int ofs, input int nbytes, input logic [159:0] val);
    for (int k = 0; k < nbytes; k++) exp_frame[ofs+k] = val[8*(nbytes-1-k) +: 8];
  endtask

  // Reference frame built byte by byte from the currently driven inputs.
  task automatic build_frame();
    logic [7:0] sum;
    for (int i = 0; i < FRAME_BYTES; i++) exp_frame[i] = 8'h00;
    put_be(0, 4, 160'(price));          put_be(4, 2, 160'(qty));
    put_be(6, 4, 160'(MsgSeqNum));      put_be(10, 4, 160'(epoch_s));
    put_be(14, 2, 160'(ms));            put_be(16, 2, 160'(session_id));
    put_be(18, 2, 160'(cm_id));         put_be(20, 1, 160'(ExecType));
    put_be(21, 4, 160'(investor_acno)); put_be(25, 1, 160'(investor_flag));
    put_be(26, 1, 160'(side));          put_be(27, 1, 160'(OrdType));
    put_be(28, 1, 160'(TimeInForce));
    for (int i = 0; i < 5; i++) exp_frame[29+i] = order_no[i];
    put_be(34, 4, 160'(ord_id));
    for (int i = 0; i < 8; i++) exp_frame[38+i] = user_def[i];
    put_be(46, 1, 160'(symbol_type));   put_be(47, 20, sym);
    sum = 8'h00;
    for (int i = 0; i < 67; i++) sum = sum + exp_frame[i];
    exp_frame[67] = sum;
  endtask

  task automatic push_frame();
    beat_t b;
    for (int n = 0; n < 3; n++) begin
      b.data = '0;
      for (int k = 0; k < 32; k++) b.data[255-8*k -: 8] = exp_frame[32*n+k];
      b.last = (n == 2);
      b.cnt  = 3'(n + 1);
      sb.push_back(b);
    end
  endtask

  task automatic set_msg_a();
    price = 32'd10000; qty = 16'd2; MsgSeqNum = 32'd1; epoch_s = 32'd1025;
    ms = 16'd16; session_id = 16'd2; cm_id = 16'd3; ExecType = 8'd4;
    investor_acno = 32'd5; investor_flag = 8'd6; side = 8'd1; OrdType = 8'd0;
    TimeInForce = 8'd7; ord_id = 32'd33; symbol_type = 8'd1; sym = 160'd1025;
    for (int i = 0; i < 5; i++) order_no[i] = 8'(8 + i);
    for (int i = 0; i < 8; i++) user_def[i] = 8'(i);
  endtask

  task automatic set_msg_rand();
    price = $urandom(); qty = 16'($urandom()); MsgSeqNum = $urandom();
    epoch_s = $urandom(); ms = 16'($urandom()); session_id = 16'($urandom());
    cm_id = 16'($urandom()); ExecType = 8'($urandom()); investor_acno = $urandom();
    investor_flag = 8'($urandom()); side = 8'($urandom()); OrdType = 8'($urandom());
    TimeInForce = 8'($urandom()); ord_id = $urandom(); symbol_type = 8'($urandom());
    sym = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < 5; i++) order_no[i] = 8'($urandom());
    for (int i = 0; i < 8; i++) user_def[i] = 8'($urandom());
  endtask

  // Capture the current inputs as a frame: model it, then pulse enable.
  task automatic start_frame();
    build_frame();
    push_frame();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic consume_beat(input string tag);
    beat_t e;
    int    waited = 0;
    axis.tready = 1'b1;
    while (!axis.tvalid && waited < 16) begin
      tick();
      waited++;
    end
    check({tag, " tvalid"}, 256'(axis.tvalid), 256'(1));
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty expected pending beat", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " data"},  axis.data,        e.data);
      check({tag, " tlast"}, 256'(axis.tlast), 256'(e.last));
      check({tag, " cnt"},   256'(axis.cnt),   256'(e.cnt));
      if (e.cnt >= 3'd1 && e.cnt <= 3'd3) obs_beat[e.cnt] = axis.data;
    end
    tick();
  endtask

  initial begin
    resetn = 1'b1; enable = 1'b0; axis.tready = 1'b0;
    set_msg_rand();
    tick(); tick();
    check_idle("reset");
    resetn = 1'b0;
    tick();

    // Message A: full-rate transfer, inputs scrambled right after capture.
    set_msg_a();
    start_frame();
    price = 32'hDEADBEEF; sym = '1;
    for (int n = 1; n <= 3; n++) consume_beat($sformatf("A beat%0d", n));
    check_idle("A done");
    check("A price", 256'(obs_beat[1][255:224]), 256'(32'h00002710));
    check("A qty",   256'(obs_beat[1][223:208]), 256'(16'h0002));
    check("A beat3", obs_beat[3], {24'h000401, 8'hE0, 224'h0});

    // Message B: altered fields shift the checksum.
    set_msg_a();
    epoch_s = 32'd1027; TimeInForce = 8'd63; symbol_type = 8'd2; sym = 160'd1027;
    start_frame();
    for (int n = 1; n <= 3; n++) consume_beat($sformatf("B beat%0d", n));
    check("B sym tail", 256'(obs_beat[3][255:232]), 256'(24'h000403));
    check("B checksum", 256'(obs_beat[3][231:224]), 256'(exp_frame[67]));
    check_idle("B done");

    // Message C: backpressure on beat 2 with an enable pulse that must be ignored.
    set_msg_rand();
    start_frame();
    consume_beat("C beat1");
    axis.tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("C hold%0d data", i), axis.data, sb[0].data);
      check($sformatf("C hold%0d cnt", i), 256'(axis.cnt), 256'(2));
      check($sformatf("C hold%0d tvalid", i), 256'(axis.tvalid), 256'(1));
      check($sformatf("C hold%0d tlast", i), 256'(axis.tlast), 256'(0));
      enable = (i == 1);
      price = $urandom();
      tick();
    end
    enable = 1'b0;
    consume_beat("C beat2");
    enable = 1'b1;
    consume_beat("C beat3");
    enable = 1'b0;
    check_idle("C done");
    tick();
    check_idle("C no requeue");

    // Message D: reset in the middle of the frame, then a clean frame E.
    set_msg_rand();
    start_frame();
    consume_beat("D beat1");
    check("D cnt before reset", 256'(axis.cnt), 256'(2));
    axis.tready = 1'b0;
    resetn = 1'b1;
    tick();
    check_idle("D after reset");
    sb.delete();
    resetn = 1'b0;
    set_msg_rand();
    start_frame();
    for (int n = 1; n <= 3; n++) consume_beat($sformatf("E beat%0d", n));
    check_idle("E done");
    check("scoreboard drained", 256'(sb.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
